ldl_solver: RTL and testbench
=============================

Name: ldl_solver

Overview:
- Consumes the LDL^T factorisation left by the LDL decomposer: unit-lower L strictly below the diagonal of the shared matrix, D in the shared vector_reg.
- Solves R·x = b by forward substitution (L·y = b), diagonal scaling (z = y / D) and back substitution (L^T·x = z).
- Produces x = R^-1·b for the LCMV filter-weight stage.
- Shares the matrix read ports and fp_vector_mult_alu with the decomposer; a top-level mux selects the owner, as the initialisation mux does in simulation.

Parameters:
NUM_ROWS, 4, matrix dimension / vector length
WIDTH, 32, IEEE-754 single-precision scalar width
ROW_ADDR_WIDTH, $clog2(NUM_ROWS), row/column index width (derived)
ROW_SIZE, NUM_ROWS*WIDTH, packed vector width (derived); element k at [k*WIDTH +: WIDTH]

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  one-cycle pulse; latches b_in and begins a solve
b_in  in  ROW_SIZE  right-hand side b
finished  out  1  high while x_out is valid; held until next accepted start
x_out  out  ROW_SIZE  solution x
row_addr  out  ROW_ADDR_WIDTH  matrix row read index
row_addr_ready  out  1  one-cycle row read request
row_valid  in  1  row_out valid
row_out  in  ROW_SIZE  matrix row data
col_addr  out  ROW_ADDR_WIDTH  matrix column read index
col_addr_ready  out  1  one-cycle column read request
col_valid  in  1  col_out valid
col_out  in  ROW_SIZE  matrix column data
dot_product_a, dot_product_b  out  ROW_SIZE  ALU operands
dot_product_c  out  WIDTH  ALU addend
dot_product_enable  out  NUM_ROWS  per-lane enable
dot_product_mode  out  1  1 = dot-product mode
vector_mult_alu_ready  in  1  ALU can accept an operation
dot_product_valid  in  1  dot_product_out valid
dot_product_out  in  WIDTH  c + sum over enabled k of a_k*b_k
d_out  in  ROW_SIZE  D vector
div_a, div_b  out  WIDTH  divider numerator, denominator
div_start  out  1  one-cycle divider request
div_valid  in  1  div_out valid
div_out  in  WIDTH  div_a / div_b

Behaviour:
- Reset (rst=0 at a clock edge):
  - State returns to IDLE from any state, including mid-solve.
  - finished=0, x_out=0, all request pulses 0, dot_product_mode=0, internal y/z vectors cleared.
  - Any response (row_valid, col_valid, dot_product_valid, div_valid) arriving after reset is ignored.
- FSM states: IDLE, FWD_REQ, FWD_WAIT_ROW, FWD_ISSUE, FWD_WAIT_DOT, DIV_ISSUE, DIV_WAIT, BWD_REQ, BWD_WAIT_COL, BWD_ISSUE, BWD_WAIT_DOT, DONE.
- IDLE/DONE + start=1:
  - Latch b_in, clear finished, set i=0, go to FWD_REQ.
  - start in any other state is ignored.
- Forward pass, i = 0..NUM_ROWS-1:
  - FWD_REQ: row_addr=i, row_addr_ready=1 for exactly one cycle.
  - FWD_WAIT_ROW: wait for row_valid; capture row_out.
  - FWD_ISSUE: when vector_mult_alu_ready=1, drive a=row, b=negY, c=b_i, enable[k]=(k<i), mode=1.
    - negY is the y vector with sign bits inverted; produced by a bit flip, no FP negation unit.
    - Operands are held stable until dot_product_valid.
  - FWD_WAIT_DOT: on valid, y_i = dot_product_out. i==NUM_ROWS-1 -> DIV_ISSUE with i=0, else i+1 -> FWD_REQ.
  - Row 0 goes through the ALU with enable=0 and yields y_0=b_0.
  - Diagonal and upper-triangle matrix contents are never enabled and are don't-care.
- Diagonal, i = 0..NUM_ROWS-1:
  - div_a=y_i, div_b=d_out[i], div_start pulse for one cycle; wait for div_valid; z_i=div_out.
  - After the last i, set i=NUM_ROWS-1 and go to BWD_REQ.
  - d_i=0 is not checked; the result follows the divider's IEEE semantics.
- Backward pass, i = NUM_ROWS-1 down to 0:
  - Column read of col i (col_addr=i, one-cycle col_addr_ready, wait col_valid).
  - Then a=col, b=negX, c=z_i, enable[k]=(k>i); x_i = dot_product_out.
  - x_i is written into x_out as soon as it is produced.
  - After i==0 (no wrap to NUM_ROWS-1) -> DONE.
- DONE: finished=1, x_out stable; mode returns to 0.
- At most one outstanding request per port at any time. Latency is data-dependent: a bench must wait on finished, not count cycles.

Test Plan:
- Identity: L=0 below diag, upper=0, D=[1,1,1,1], b=[1,2,3,4] -> finished=1, x=[1,2,3,4].
- Factor of R={{1,-1,1,0},{-1,2,-1,2},{1,-1,5,2},{0,2,2,6}}: L21=-1, L31=1, L41=0, L32=0, L42=2, L43=0.5, D=[1,1,4,1], b=[1,2,7,10] -> x=[1,1,1,1] (rel err <1e-6).
- Same L/D with diagonal and upper triangle filled with 99.0 -> x unchanged [1,1,1,1].
- Same L/D, extra start pulses issued during FWD_WAIT_DOT and BWD_WAIT_COL -> ignored; single result x=[1,1,1,1].
- rst=0 for one cycle during DIV_WAIT, then new start with identity/b=[5,6,7,8] -> finished=0, x_out=0 after reset; final x=[5,6,7,8]; stale div_valid ignored.
- Back-to-back: second start while finished=1 -> finished drops next cycle, second result correct; ALU stall (vector_mult_alu_ready=0 for 5 cycles) only delays the result.

Source files
------------

// File: rtl/ldl_solver.sv
// Solves R*x = b from an in-place LDL^T factorisation: forward substitution through
// unit-lower L, scaling by D, then back substitution through L^T, on shared ALU/divider.
module ldl_solver #(
  parameter int NUM_ROWS       = 4,
  parameter int WIDTH          = 32,
  parameter int ROW_ADDR_WIDTH = $clog2(NUM_ROWS),
  parameter int ROW_SIZE       = NUM_ROWS * WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROW_SIZE-1:0]       b_in,
  output logic                      finished,
  output logic [ROW_SIZE-1:0]       x_out,
  output logic [ROW_ADDR_WIDTH-1:0] row_addr,
  output logic                      row_addr_ready,
  input  logic                      row_valid,
  input  logic [ROW_SIZE-1:0]       row_out,
  output logic [ROW_ADDR_WIDTH-1:0] col_addr,
  output logic                      col_addr_ready,
  input  logic                      col_valid,
  input  logic [ROW_SIZE-1:0]       col_out,
  output logic [ROW_SIZE-1:0]       dot_product_a,
  output logic [ROW_SIZE-1:0]       dot_product_b,
  output logic [WIDTH-1:0]          dot_product_c,
  output logic [NUM_ROWS-1:0]       dot_product_enable,
  output logic                      dot_product_mode,
  input  logic                      vector_mult_alu_ready,
  input  logic                      dot_product_valid,
  input  logic [WIDTH-1:0]          dot_product_out,
  input  logic [ROW_SIZE-1:0]       d_out,
  output logic [WIDTH-1:0]          div_a,
  output logic [WIDTH-1:0]          div_b,
  output logic                      div_start,
  input  logic                      div_valid,
  input  logic [WIDTH-1:0]          div_out
);

  typedef enum logic [3:0] {
    IDLE,
    FWD_REQ,
    FWD_WAIT_ROW,
    FWD_ISSUE,
    FWD_WAIT_DOT,
    DIV_ISSUE,
    DIV_WAIT,
    BWD_REQ,
    BWD_WAIT_COL,
    BWD_ISSUE,
    BWD_WAIT_DOT,
    DONE
  } state_t;

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_IDX = ROW_ADDR_WIDTH'(NUM_ROWS - 1);

  state_t                    state_reg, state_next;
  logic [ROW_ADDR_WIDTH-1:0] idx_reg;
  logic [ROW_SIZE-1:0]       b_reg;
  logic [ROW_SIZE-1:0]       y_reg;
  logic [ROW_SIZE-1:0]       z_reg;
  logic [ROW_SIZE-1:0]       x_reg;
  logic [ROW_SIZE-1:0]       line_reg;
  logic                      finished_reg;

  logic [ROW_SIZE-1:0]       neg_y;
  logic [ROW_SIZE-1:0]       neg_x;
  logic [NUM_ROWS-1:0]       fwd_en;
  logic [NUM_ROWS-1:0]       bwd_en;
  logic [31:0]               sel_base;
  logic [WIDTH-1:0]          b_sel;
  logic [WIDTH-1:0]          y_sel;
  logic [WIDTH-1:0]          z_sel;
  logic [WIDTH-1:0]          d_sel;
  logic                      idx_last;
  logic                      idx_first;

  // Negation is a sign-bit flip; lane enables pick the strictly-lower (forward)
  // or strictly-upper (backward) part of the fetched row/column.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_lane
      assign neg_y[gi*WIDTH +: WIDTH] = {~y_reg[gi*WIDTH + WIDTH - 1], y_reg[gi*WIDTH +: WIDTH-1]};
      assign neg_x[gi*WIDTH +: WIDTH] = {~x_reg[gi*WIDTH + WIDTH - 1], x_reg[gi*WIDTH +: WIDTH-1]};
      assign fwd_en[gi] = (ROW_ADDR_WIDTH'(gi) < idx_reg);
      assign bwd_en[gi] = (ROW_ADDR_WIDTH'(gi) > idx_reg);
    end
  endgenerate

  assign sel_base  = 32'(idx_reg) * 32'(WIDTH);
  assign b_sel     = b_reg[sel_base +: WIDTH];
  assign y_sel     = y_reg[sel_base +: WIDTH];
  assign z_sel     = z_reg[sel_base +: WIDTH];
  assign d_sel     = d_out[sel_base +: WIDTH];
  assign idx_last  = (idx_reg == LAST_IDX);
  assign idx_first = (idx_reg == '0);

  assign row_addr = idx_reg;
  assign col_addr = idx_reg;
  assign div_a    = y_sel;
  assign div_b    = d_sel;
  assign finished = finished_reg;
  assign x_out    = x_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    row_addr_ready     = 1'b0;
    col_addr_ready     = 1'b0;
    div_start          = 1'b0;
    dot_product_mode   = 1'b0;
    dot_product_a      = line_reg;
    dot_product_b      = neg_y;
    dot_product_c      = b_sel;
    dot_product_enable = fwd_en;

    case (state_reg)
      IDLE, DONE: begin
        if (start) state_next = FWD_REQ;
      end
      FWD_REQ: begin
        row_addr_ready = 1'b1;
        state_next     = FWD_WAIT_ROW;
      end
      FWD_WAIT_ROW: begin
        if (row_valid) state_next = FWD_ISSUE;
      end
      FWD_ISSUE: begin
        // The operation is offered only in a cycle the ALU can take it.
        if (vector_mult_alu_ready) begin
          dot_product_mode = 1'b1;
          state_next       = FWD_WAIT_DOT;
        end
      end
      FWD_WAIT_DOT: begin
        dot_product_mode = 1'b1;
        if (dot_product_valid) state_next = idx_last ? DIV_ISSUE : FWD_REQ;
      end
      DIV_ISSUE: begin
        div_start  = 1'b1;
        state_next = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (div_valid) state_next = idx_last ? BWD_REQ : DIV_ISSUE;
      end
      BWD_REQ: begin
        col_addr_ready     = 1'b1;
        dot_product_b      = neg_x;
        dot_product_c      = z_sel;
        dot_product_enable = bwd_en;
        state_next         = BWD_WAIT_COL;
      end
      BWD_WAIT_COL: begin
        dot_product_b      = neg_x;
        dot_product_c      = z_sel;
        dot_product_enable = bwd_en;
        if (col_valid) state_next = BWD_ISSUE;
      end
      BWD_ISSUE: begin
        dot_product_b      = neg_x;
        dot_product_c      = z_sel;
        dot_product_enable = bwd_en;
        if (vector_mult_alu_ready) begin
          dot_product_mode = 1'b1;
          state_next       = BWD_WAIT_DOT;
        end
      end
      BWD_WAIT_DOT: begin
        dot_product_b      = neg_x;
        dot_product_c      = z_sel;
        dot_product_enable = bwd_en;
        dot_product_mode   = 1'b1;
        if (dot_product_valid) state_next = idx_first ? DONE : BWD_REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_reg      <= '0;
      b_reg        <= '0;
      y_reg        <= '0;
      z_reg        <= '0;
      x_reg        <= '0;
      line_reg     <= '0;
      finished_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            b_reg        <= b_in;
            idx_reg      <= '0;
            finished_reg <= 1'b0;
          end
        end
        FWD_WAIT_ROW: begin
          if (row_valid) line_reg <= row_out;
        end
        FWD_WAIT_DOT: begin
          if (dot_product_valid) begin
            y_reg[sel_base +: WIDTH] <= dot_product_out;
            idx_reg <= idx_last ? '0 : idx_reg + 1'b1;
          end
        end
        DIV_WAIT: begin
          // Index stays at the last row so the backward pass starts there.
          if (div_valid) begin
            z_reg[sel_base +: WIDTH] <= div_out;
            if (!idx_last) idx_reg <= idx_reg + 1'b1;
          end
        end
        BWD_WAIT_COL: begin
          if (col_valid) line_reg <= col_out;
        end
        BWD_WAIT_DOT: begin
          if (dot_product_valid) begin
            x_reg[sel_base +: WIDTH] <= dot_product_out;
            if (idx_first) finished_reg <= 1'b1;
            else           idx_reg      <= idx_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ldl_solver.sv
// Directed bench for ldl_solver with behavioural matrix memory, dot-product ALU and divider.
module tb_ldl_solver;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 2;
  localparam int RS = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [RS-1:0] b_in = '0;
  logic          finished;
  logic [RS-1:0] x_out;
  logic [AW-1:0] row_addr, col_addr;
  logic          row_addr_ready, col_addr_ready;
  logic          row_valid = 1'b0;
  logic [RS-1:0] row_out = '0;
  logic          col_valid = 1'b0;
  logic [RS-1:0] col_out = '0;
  logic [RS-1:0] dot_product_a, dot_product_b;
  logic [W-1:0]  dot_product_c;
  logic [N-1:0]  dot_product_enable;
  logic          dot_product_mode;
  logic          vector_mult_alu_ready = 1'b1;
  logic          dot_product_valid = 1'b0;
  logic [W-1:0]  dot_product_out = '0;
  logic [RS-1:0] d_out = '0;
  logic [W-1:0]  div_a, div_b;
  logic          div_start;
  logic          div_valid = 1'b0;
  logic [W-1:0]  div_out = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]  mat [N][N];

  ldl_solver #(.NUM_ROWS(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .b_in(b_in),
    .finished(finished), .x_out(x_out),
    .row_addr(row_addr), .row_addr_ready(row_addr_ready),
    .row_valid(row_valid), .row_out(row_out),
    .col_addr(col_addr), .col_addr_ready(col_addr_ready),
    .col_valid(col_valid), .col_out(col_out),
    .dot_product_a(dot_product_a), .dot_product_b(dot_product_b),
    .dot_product_c(dot_product_c), .dot_product_enable(dot_product_enable),
    .dot_product_mode(dot_product_mode),
    .vector_mult_alu_ready(vector_mult_alu_ready),
    .dot_product_valid(dot_product_valid), .dot_product_out(dot_product_out),
    .d_out(d_out), .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_valid(div_valid), .div_out(div_out)
  );

  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2sp(input real v);
    logic s;
    int   e;
    int   m;
    real  a;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 8388608.0 + 0.5);
    if (m >= 8388608) begin m = 0; e++; end
    return {s, 8'(e + 127), 23'(m)};
  endfunction

  function automatic logic [RS-1:0] pack4(input real v0, input real v1, input real v2, input real v3);
    return {r2sp(v3), r2sp(v2), r2sp(v1), r2sp(v0)};
  endfunction

  function automatic logic [RS-1:0] row_of(input logic [AW-1:0] r);
    logic [RS-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = mat[r][k];
    return v;
  endfunction

  function automatic logic [RS-1:0] col_of(input logic [AW-1:0] c);
    logic [RS-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = mat[k][c];
    return v;
  endfunction

  function automatic logic [31:0] dot_model(input logic [RS-1:0] a, input logic [RS-1:0] b,
                                            input logic [W-1:0] c, input logic [N-1:0] en);
    real acc;
    acc = sp2r(c);
    for (int k = 0; k < N; k++)
      if (en[k]) acc = acc + sp2r(a[k*W +: W]) * sp2r(b[k*W +: W]);
    return r2sp(acc);
  endfunction

  // Matrix memory: 2-cycle row/column reads. Models are never reset, so
  // responses in flight across a DUT reset still arrive.
  int            row_cnt = 0;
  int            col_cnt = 0;
  logic [AW-1:0] row_pend = '0;
  logic [AW-1:0] col_pend = '0;
  always @(posedge clk) begin
    row_valid <= 1'b0;
    col_valid <= 1'b0;
    if (row_cnt > 0) begin
      row_cnt <= row_cnt - 1;
      if (row_cnt == 1) begin row_valid <= 1'b1; row_out <= row_of(row_pend); end
    end
    if (col_cnt > 0) begin
      col_cnt <= col_cnt - 1;
      if (col_cnt == 1) begin col_valid <= 1'b1; col_out <= col_of(col_pend); end
    end
    if (row_addr_ready) begin row_pend <= row_addr; row_cnt <= 2; end
    if (col_addr_ready) begin col_pend <= col_addr; col_cnt <= 2; end
  end

  int          alu_cnt = 0;
  logic [31:0] alu_res = '0;
  always @(posedge clk) begin
    dot_product_valid <= 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) begin dot_product_valid <= 1'b1; dot_product_out <= alu_res; end
    end else if (dot_product_mode && vector_mult_alu_ready && !dot_product_valid) begin
      alu_res <= dot_model(dot_product_a, dot_product_b, dot_product_c, dot_product_enable);
      alu_cnt <= 3;
    end
  end

  int          div_cnt = 0;
  logic [31:0] div_res = '0;
  always @(posedge clk) begin
    div_valid <= 1'b0;
    if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin div_valid <= 1'b1; div_out <= div_res; end
    end
    if (div_start) begin
      div_res <= r2sp(sp2r(div_a) / sp2r(div_b));
      div_cnt <= 4;
    end
  end

  // kind 0: identity factor; kind 1: worked factor, rest zero; kind 2: worked factor, rest 99.0
  task automatic load_mat(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat[r][c] = (kind == 2 && c >= r) ? r2sp(99.0) : 32'h0;
    if (kind == 0) begin
      d_out = pack4(1.0, 1.0, 1.0, 1.0);
    end else begin
      mat[1][0] = r2sp(-1.0);
      mat[2][0] = r2sp(1.0);
      mat[3][0] = r2sp(0.0);
      mat[2][1] = r2sp(0.0);
      mat[3][1] = r2sp(2.0);
      mat[3][2] = r2sp(0.5);
      d_out = pack4(1.0, 1.0, 4.0, 1.0);
    end
  endtask

  task automatic pulse_start(input logic [RS-1:0] b);
    @(negedge clk);
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (finished !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (finished !== 1'b0) begin n_bad++; $display("FAIL reset_finished: got %b expected 0", finished); end
    n_cmp++; if (x_out !== '0) begin n_bad++; $display("FAIL reset_x_out: got %h expected 0", x_out); end
    n_cmp++; if (row_addr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_row_req: got %b expected 0", row_addr_ready); end
    n_cmp++; if (col_addr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_col_req: got %b expected 0", col_addr_ready); end
    n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL reset_div_start: got %b expected 0", div_start); end
    n_cmp++; if (dot_product_mode !== 1'b0) begin n_bad++; $display("FAIL reset_mode: got %b expected 0", dot_product_mode); end
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_identity();
    int  cyc;
    real act;
    real ex[4] = '{1.0, 2.0, 3.0, 4.0};
    load_mat(0);
    pulse_start(pack4(1.0, 2.0, 3.0, 4.0));
    wait_done(cyc);
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL identity_done: finished=%b after %0d cycles, expected 1", finished, cyc); end
    for (int k = 0; k < N; k++) begin
      act = sp2r(x_out[k*W +: W]);
      n_cmp++;
      if ($isunknown(x_out[k*W +: W]) || !(((act > ex[k]) ? act - ex[k] : ex[k] - act) <= 1e-6 * ex[k]))
        begin n_bad++; $display("FAIL identity_x%0d: got %h (%f) expected %f", k, x_out[k*W +: W], act, ex[k]); end
    end
    $display("test_identity: solve took %0d cycles", cyc);
  endtask

  task automatic test_factor(input int kind, input string name);
    int  cyc;
    real act;
    load_mat(kind);
    pulse_start(pack4(1.0, 2.0, 7.0, 10.0));
    wait_done(cyc);
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL %s_done: finished=%b after %0d cycles, expected 1", name, finished, cyc); end
    for (int k = 0; k < N; k++) begin
      act = sp2r(x_out[k*W +: W]);
      n_cmp++;
      if ($isunknown(x_out[k*W +: W]) || !(((act > 1.0) ? act - 1.0 : 1.0 - act) <= 1e-6))
        begin n_bad++; $display("FAIL %s_x%0d: got %h (%f) expected 1.0", name, k, x_out[k*W +: W], act); end
    end
    $display("test_factor %s: solve took %0d cycles", name, cyc);
  endtask

  task automatic test_start_ignored();
    int  cyc;
    real act;
    load_mat(1);
    pulse_start(pack4(1.0, 2.0, 7.0, 10.0));
    cyc = 0;
    while (dot_product_mode !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    n_cmp++; if (dot_product_mode !== 1'b1) begin n_bad++; $display("FAIL ignore_reach_fwd_dot: mode=%b expected 1", dot_product_mode); end
    @(negedge clk);
    b_in  = pack4(5.0, 6.0, 7.0, 8.0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (col_addr_ready !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    n_cmp++; if (col_addr_ready !== 1'b1) begin n_bad++; $display("FAIL ignore_reach_bwd_col: col_addr_ready=%b expected 1", col_addr_ready); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL ignore_done: finished=%b expected 1", finished); end
    for (int k = 0; k < N; k++) begin
      act = sp2r(x_out[k*W +: W]);
      n_cmp++;
      if ($isunknown(x_out[k*W +: W]) || !(((act > 1.0) ? act - 1.0 : 1.0 - act) <= 1e-6))
        begin n_bad++; $display("FAIL ignore_x%0d: got %h (%f) expected 1.0", k, x_out[k*W +: W], act); end
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_reset_mid();
    int  cyc;
    real act;
    real ex[4] = '{5.0, 6.0, 7.0, 8.0};
    load_mat(1);
    pulse_start(pack4(1.0, 2.0, 7.0, 10.0));
    cyc = 0;
    while (div_start !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    n_cmp++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL rmid_reach_div: div_start=%b expected 1", div_start); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (finished !== 1'b0) begin n_bad++; $display("FAIL rmid_finished: got %b expected 0", finished); end
    n_cmp++; if (x_out !== '0) begin n_bad++; $display("FAIL rmid_x_out: got %h expected 0", x_out); end
    n_cmp++; if (dot_product_mode !== 1'b0) begin n_bad++; $display("FAIL rmid_mode: got %b expected 0", dot_product_mode); end
    load_mat(0);
    pulse_start(pack4(5.0, 6.0, 7.0, 8.0));
    wait_done(cyc);
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL rmid_done: finished=%b expected 1", finished); end
    for (int k = 0; k < N; k++) begin
      act = sp2r(x_out[k*W +: W]);
      n_cmp++;
      if ($isunknown(x_out[k*W +: W]) || !(((act > ex[k]) ? act - ex[k] : ex[k] - act) <= 1e-6 * ex[k]))
        begin n_bad++; $display("FAIL rmid_x%0d: got %h (%f) expected %f", k, x_out[k*W +: W], act, ex[k]); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    int  cyc;
    real act;
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL b2b_pre_finished: got %b expected 1", finished); end
    load_mat(1);
    vector_mult_alu_ready = 1'b0;
    pulse_start(pack4(1.0, 2.0, 7.0, 10.0));
    n_cmp++; if (finished !== 1'b0) begin n_bad++; $display("FAIL b2b_finished_drop: got %b expected 0", finished); end
    repeat (5) @(negedge clk);
    n_cmp++; if (dot_product_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_valid: got %b expected 0", dot_product_valid); end
    vector_mult_alu_ready = 1'b1;
    wait_done(cyc);
    n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL b2b_done: finished=%b expected 1", finished); end
    for (int k = 0; k < N; k++) begin
      act = sp2r(x_out[k*W +: W]);
      n_cmp++;
      if ($isunknown(x_out[k*W +: W]) || !(((act > 1.0) ? act - 1.0 : 1.0 - act) <= 1e-6))
        begin n_bad++; $display("FAIL b2b_x%0d: got %h (%f) expected 1.0", k, x_out[k*W +: W], act); end
    end
    $display("test_back_to_back: second solve took %0d cycles after stall", cyc);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_factor(1, "factor");
    test_factor(2, "dont_care");
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
